// File: rtl/uart_cmd_responder_pkg.sv
// Shared link definitions for the main-to-module UART command link.
// Command bytes, default NAK and the responder FSM state encodings.
package uart_cmd_responder_pkg;

  localparam logic [7:0] CMD_TURN_ON      = 8'hEE;
  localparam logic [7:0] CMD_TURN_OFF     = 8'h55;
  localparam logic [7:0] CMD_TOGGLE       = 8'hC3;
  localparam logic [7:0] NAK_BYTE_DEFAULT = 8'h00;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StDecode = 2'd1;
  localparam logic [1:0] StStart  = 2'd2;
  localparam logic [1:0] StBusy   = 2'd3;

endpackage

// File: rtl/uart_cmd_responder.sv
// Decodes link command bytes from uart_rx, drives the gate-enable level and echoes
// each accepted command (or NAK) back through uart_tx.
module uart_cmd_responder
  import uart_cmd_responder_pkg::*;
#(
  parameter int unsigned BUSY_TIMEOUT = 1000,
  parameter logic [7:0]  NAK_BYTE     = NAK_BYTE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       rx_parity_error,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       out_en,
  output logic       cmd_strobe,
  output logic       overrun,
  output logic       tx_timeout
);

  localparam int unsigned CntW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(BUSY_TIMEOUT - 1);

  logic [1:0]      state_q, state_d;
  logic [7:0]      cmd_q, cmd_d;
  logic            perr_q, perr_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            out_en_q, out_en_d;
  logic            strobe_q, strobe_d;
  logic            overrun_q, overrun_d;
  logic            timeout_q, timeout_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rose_q, rose_d;
  logic            start_c;

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    perr_d    = perr_q;
    tx_data_d = tx_data_q;
    out_en_d  = out_en_q;
    strobe_d  = 1'b0;
    overrun_d = overrun_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    rose_d    = rose_q;
    start_c   = 1'b0;

    // No queuing: any byte arriving outside IDLE is dropped.
    if (rx_done && (state_q != StIdle)) overrun_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (rx_done) begin
          cmd_d   = rx_data;
          perr_d  = rx_parity_error;
          state_d = StDecode;
        end
      end
      StDecode: begin
        state_d   = StStart;
        tx_data_d = NAK_BYTE;
        if (!perr_q) begin
          case (cmd_q)
            CMD_TURN_ON: begin
              out_en_d  = 1'b1;
              tx_data_d = cmd_q;
              strobe_d  = 1'b1;
            end
            CMD_TURN_OFF: begin
              out_en_d  = 1'b0;
              tx_data_d = cmd_q;
              strobe_d  = 1'b1;
            end
            CMD_TOGGLE: begin
              out_en_d  = ~out_en_q;
              tx_data_d = cmd_q;
              strobe_d  = 1'b1;
            end
            default: ;
          endcase
        end
      end
      StStart: begin
        if (!tx_busy) begin
          start_c = 1'b1;
          cnt_d   = '0;
          rose_d  = 1'b0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (rose_q) begin
          if (!tx_busy) state_d = StIdle;
        end else if (tx_busy) begin
          rose_d = 1'b1;
        end else if (cnt_q >= CntLast) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cmd_q     <= 8'h00;
      perr_q    <= 1'b0;
      tx_data_q <= 8'h00;
      out_en_q  <= 1'b0;
      strobe_q  <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      rose_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      perr_q    <= perr_d;
      tx_data_q <= tx_data_d;
      out_en_q  <= out_en_d;
      strobe_q  <= strobe_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      rose_q    <= rose_d;
    end
  end

  // Gated so a reset landing in START can never leak a start pulse to uart_tx.
  assign tx_start   = start_c & ~reset;
  assign tx_data    = tx_data_q;
  assign out_en     = out_en_q;
  assign cmd_strobe = strobe_q;
  assign overrun    = overrun_q;
  assign tx_timeout = timeout_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Self-checking bench for uart_cmd_responder: directed scenarios plus randomized
// command streams against a behavioural model of the gate level, echo and flags.
module tb_uart_cmd_responder;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_parity_error;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       out_en;
  logic       cmd_strobe;
  logic       overrun;
  logic       tx_timeout;

  int n_cmp;
  int n_err;

  // Behavioural model state
  logic m_out_en;
  logic m_ovr;
  logic m_tout;

  uart_cmd_responder #(
    .BUSY_TIMEOUT(16),
    .NAK_BYTE    (8'h00)
  ) u_dut (
    .clk            (clk),
    .reset          (reset),
    .rx_data        (rx_data),
    .rx_done        (rx_done),
    .rx_parity_error(rx_parity_error),
    .tx_busy        (tx_busy),
    .tx_start       (tx_start),
    .tx_data        (tx_data),
    .out_en         (out_en),
    .cmd_strobe     (cmd_strobe),
    .overrun        (overrun),
    .tx_timeout     (tx_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle, drive this cycle's inputs, let combinational outputs settle.
  task automatic tick(input logic d_done, input logic [7:0] d_data, input logic d_perr,
                      input logic d_busy);
    @(posedge clk);
    #1;
    rx_done         = d_done;
    rx_data         = d_data;
    rx_parity_error = d_perr;
    tx_busy         = d_busy;
    #1;
  endtask

  // One full command transaction: pre = cycles tx_busy is held from N+2,
  // blen = cycles tx_busy is high after tx_start, ovr = inject a byte during the echo.
  task automatic send_cmd(input logic [7:0] b, input logic perr, input int pre,
                          input int blen, input bit ovr, input string tag);
    logic       valid;
    logic       old_en;
    logic [7:0] echo;
    logic [7:0] ob;
    valid  = !perr && (b == 8'hEE || b == 8'h55 || b == 8'hC3);
    old_en = m_out_en;
    if (valid) begin
      if (b == 8'hEE) m_out_en = 1'b1;
      else if (b == 8'h55) m_out_en = 1'b0;
      else m_out_en = ~m_out_en;
    end
    echo = valid ? b : 8'h00;

    tick(1'b1, b, perr, 1'b0);
    n_cmp++;
    if (tx_start !== 1'b0) begin
      n_err++; $display("FAIL %s idle_start: got %b want 0", tag, tx_start);
    end
    tick(1'b0, 8'($urandom), 1'b0, 1'b0);
    n_cmp++;
    if (out_en !== old_en || cmd_strobe !== 1'b0) begin
      n_err++;
      $display("FAIL %s decode_cycle: out_en=%b strobe=%b want %b/0", tag, out_en, cmd_strobe,
               old_en);
    end
    tick(1'b0, 8'($urandom), 1'b0, pre > 0);
    n_cmp++;
    if (out_en !== m_out_en || cmd_strobe !== valid || tx_data !== echo
        || tx_start !== (pre == 0)) begin
      n_err++;
      $display("FAIL %s n_plus_2: en=%b strobe=%b data=%h start=%b want %b/%b/%h/%b", tag,
               out_en, cmd_strobe, tx_data, tx_start, m_out_en, valid, echo, pre == 0);
    end
    if (pre > 0) begin
      for (int i = 1; i < pre; i++) begin
        tick(1'b0, 8'($urandom), 1'b0, 1'b1);
        n_cmp++;
        if (tx_start !== 1'b0 || cmd_strobe !== 1'b0) begin
          n_err++;
          $display("FAIL %s deferred_start: start=%b strobe=%b want 0/0", tag, tx_start,
                   cmd_strobe);
        end
      end
      tick(1'b0, 8'($urandom), 1'b0, 1'b0);
      n_cmp++;
      if (tx_start !== 1'b1 || tx_data !== echo) begin
        n_err++;
        $display("FAIL %s late_start: start=%b data=%h want 1/%h", tag, tx_start, tx_data, echo);
      end
    end
    for (int i = 0; i < blen; i++) begin
      ob = m_out_en ? 8'h55 : 8'hEE;
      tick(ovr && i == 0, ob, 1'b0, 1'b1);
      n_cmp++;
      if (tx_start !== 1'b0 || cmd_strobe !== 1'b0 || tx_data !== echo) begin
        n_err++;
        $display("FAIL %s busy_phase: start=%b strobe=%b data=%h want 0/0/%h", tag, tx_start,
                 cmd_strobe, tx_data, echo);
      end
    end
    if (ovr) m_ovr = 1'b1;
    tick(1'b0, 8'($urandom), 1'b0, 1'b0);
    n_cmp++;
    if (tx_start !== 1'b0 || out_en !== m_out_en || overrun !== m_ovr
        || tx_timeout !== m_tout) begin
      n_err++;
      $display("FAIL %s end_echo: start=%b en=%b ovr=%b tout=%b want 0/%b/%b/%b", tag, tx_start,
               out_en, overrun, tx_timeout, m_out_en, m_ovr, m_tout);
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    m_out_en = 1'b0; m_ovr = 1'b0; m_tout = 1'b0;
    n_cmp++;
    if ({tx_start, tx_data, out_en, cmd_strobe, overrun, tx_timeout} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_values: got %b_%h_%b%b%b%b want all zero", tx_start, tx_data,
               out_en, cmd_strobe, overrun, tx_timeout);
    end
  endtask

  task automatic test_turn_on();
    send_cmd(8'hEE, 1'b0, 0, 100, 1'b0, "turn_on");
    n_cmp++;
    if (out_en !== 1'b1) begin
      n_err++; $display("FAIL turn_on_level: got %b want 1", out_en);
    end
  endtask

  task automatic test_toggle_off();
    send_cmd(8'hC3, 1'b0, 0, 8, 1'b0, "toggle_1");
    n_cmp++;
    if (out_en !== 1'b0) begin
      n_err++; $display("FAIL toggle_to_0: got %b want 0", out_en);
    end
    send_cmd(8'hC3, 1'b0, 0, 8, 1'b0, "toggle_2");
    n_cmp++;
    if (out_en !== 1'b1) begin
      n_err++; $display("FAIL toggle_to_1: got %b want 1", out_en);
    end
    send_cmd(8'hEE, 1'b0, 0, 3, 1'b0, "repeat_on");
    send_cmd(8'h55, 1'b0, 0, 8, 1'b0, "turn_off");
    n_cmp++;
    if (out_en !== 1'b0 || tx_data !== 8'h55) begin
      n_err++; $display("FAIL turn_off: en=%b data=%h want 0/55", out_en, tx_data);
    end
  endtask

  task automatic test_invalid_parity();
    send_cmd(8'h42, 1'b0, 0, 5, 1'b0, "invalid");
    send_cmd(8'hEE, 1'b1, 0, 5, 1'b0, "parity");
    n_cmp++;
    if (out_en !== 1'b0 || tx_data !== 8'h00) begin
      n_err++; $display("FAIL parity_nak: en=%b data=%h want 0/00", out_en, tx_data);
    end
  endtask

  task automatic test_timeout();
    tick(1'b1, 8'h55, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    m_out_en = 1'b0;
    n_cmp++;
    if (tx_start !== 1'b1) begin
      n_err++; $display("FAIL timeout_start: got %b want 1", tx_start);
    end
    for (int k = 1; k <= 16; k++) begin
      tick(1'b0, 8'h00, 1'b0, 1'b0);
      n_cmp++;
      if (tx_timeout !== 1'b0 || tx_start !== 1'b0) begin
        n_err++;
        $display("FAIL timeout_early k=%0d: tout=%b start=%b want 0/0", k, tx_timeout, tx_start);
      end
    end
    // Back in IDLE: a byte here must be accepted, not counted as overrun.
    tick(1'b1, 8'hEE, 1'b0, 1'b0);
    m_tout = 1'b1;
    n_cmp++;
    if (tx_timeout !== 1'b1) begin
      n_err++; $display("FAIL timeout_flag: got %b want 1", tx_timeout);
    end
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    m_out_en = 1'b1;
    n_cmp++;
    if (tx_start !== 1'b1 || out_en !== 1'b1 || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_recover: start=%b en=%b ovr=%b want 1/1/0", tx_start, out_en,
               overrun);
    end
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_busy_overrun();
    send_cmd(8'hC3, 1'b0, 20, 4, 1'b0, "busy_defer");
    send_cmd(8'hC3, 1'b0, 0, 6, 1'b1, "overrun");
    n_cmp++;
    if (overrun !== 1'b1 || out_en !== 1'b1) begin
      n_err++; $display("FAIL overrun_flag: ovr=%b en=%b want 1/1", overrun, out_en);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0: b = 8'hEE;
        1: b = 8'h55;
        2: b = 8'hC3;
        default: b = 8'($urandom);
      endcase
      send_cmd(b, $urandom_range(0, 4) == 0, $urandom_range(0, 3), $urandom_range(1, 6),
               $urandom_range(0, 3) == 0, "random");
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 8'hEE, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    n_cmp++;
    if (out_en !== 1'b1 || tx_start !== 1'b0) begin
      n_err++; $display("FAIL mid_pre: en=%b start=%b want 1/0", out_en, tx_start);
    end
    @(posedge clk);
    #1;
    reset   = 1'b1;
    tx_busy = 1'b0;
    #1;
    n_cmp++;
    if (tx_start !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_start: got %b want 0", tx_start);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    m_out_en = 1'b0; m_ovr = 1'b0; m_tout = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if ({tx_start, tx_data, out_en, cmd_strobe, overrun, tx_timeout} !== 13'd0) begin
        n_err++;
        $display("FAIL mid_reset_outputs k=%0d: got %b_%h_%b%b%b%b want all zero", k, tx_start,
                 tx_data, out_en, cmd_strobe, overrun, tx_timeout);
      end
      tick(1'b0, 8'h00, 1'b0, 1'b0);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    rx_data = 8'h00;
    rx_done = 1'b0;
    rx_parity_error = 1'b0;
    tx_busy = 1'b0;
    m_out_en = 1'b0; m_ovr = 1'b0; m_tout = 1'b0;
    test_reset();
    test_turn_on();
    test_toggle_off();
    test_invalid_parity();
    test_timeout();
    test_busy_overrun();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
